jtpocket_bridge_host: RTL and testbench
=======================================

# jtpocket_bridge_host

SPI initiator for the Pocket bridge interface: it plays the APF host side that drives the core's bridge target. It turns single-word read/write requests from a bench sequencer, or a debug controller, into framed SPI transactions on `bridge_spiclk`, `bridge_spimosi`, `bridge_spimiso` and `bridge_spiss`. It returns read data and a completion pulse. It is instantiated in the Pocket simulation harness facing `apf_top` and is written synthesizable so it can also drive a bridge target on hardware test rigs.

## Interface
- `CLKDIV`, default 2: `clk` cycles per spiclk half-period, legal values ≥1.
- `TURN`, default 8: turnaround spiclk periods between the address and the read data.
- `clk` in, 1 bit: only clock. All logic is on the rising edge.
- `rst_n` in, 1 bit: reset, asynchronous assertion, active-low. The clock is named `clk` and the reset `rst_n`; polarity and synchronicity are fixed.
- `req` in, 1 bit: transaction request, level-sensitive, sampled only in IDLE.
- `we` in, 1 bit: 1 = write, 0 = read. Latched at accept.
- `addr` in, 32 bits: bridge address, latched at accept.
- `din` in, 32 bits: write data, latched at accept.
- `dout` out, 32 bits: last read word.
- `busy` out, 1 bit: transaction or post-frame gap in progress.
- `done` out, 1 bit: one-cycle completion pulse.
- `spiclk` out, 1 bit: serial clock, idles low.
- `spimosi` out, 1 bit: serial data to the target.
- `spimiso` in, 1 bit: serial data from the target.
- `spiss` out, 1 bit: slave select, active-low.

## Operation
- Frame layout, MSB first:
  - Opcode, 8 bits: 8'h01 = write, 8'h02 = read.
  - Address, 32 bits.
  - Write: 32 data bits driven on mosi.
  - Read: TURN periods with mosi=0, then 32 data bits sampled from miso.
- Frame length N in spiclk periods: write N=72; read N=72+TURN.
- States:
  - IDLE: if req=1, accept: latch we/addr/din, load the shift register, go to SHIFT.
  - SHIFT: runs N spiclk periods, then goes to HOLD.
  - HOLD: keeps ss low for CLKDIV cycles, then raises ss, pulses done, goes to GAP.
  - GAP: lasts 2·CLKDIV cycles, then returns to IDLE.
- SPI mode 0 (spiclk idles low, target samples on the rising edge):
  - Each period is a low phase of CLKDIV cycles followed by a high phase of CLKDIV cycles.
  - mosi changes only at the clk edge that starts a low phase.
- miso is sampled at the clk edge that ends a high phase, where spiclk goes 1→0, and shifts into the read register.
- mosi is 0 outside the opcode, address and write-data bits.
- A half-period counter must cover 1..CLKDIV. A bit counter must cover 0..(72+TURN−1).
- dout loads the 32 read bits at the done edge and holds them otherwise. Writes never change dout.
- req while busy=1 is ignored; it is neither queued nor latched. Changes to we/addr/din after accept are ignored.
- If req is held high continuously, transactions run back-to-back. busy is low for exactly one cycle between them.

## Timing
- Reset values (asynchronous, immediate, also when reset is applied mid-frame): spiss=1, spiclk=0, spimosi=0, busy=0, done=0, dout=0, state=IDLE.
- After rst_n deasserts, the first accept happens no earlier than the first clk edge with req=1.
- Accept edge E0 (the edge with state=IDLE and req=1):
  - spiss=0, busy=1 and spimosi=opcode bit 7 all become valid from E0.
  - Bit k has its low phase at E0+2k·CLKDIV and rises at E0+(2k+1)·CLKDIV.
- Last falling edge at E0+2N·CLKDIV. spiss rises and done=1 at E0+(2N+1)·CLKDIV. busy falls at E0+(2N+3)·CLKDIV.
- With CLKDIV=2, TURN=8: write done at E0+290, read done at E0+322.
- Minimum spiss high time between frames is 2·CLKDIV+1 cycles.

## Test plan
- Write addr=0xF8000000, din=0x12345678, CLKDIV=2 → the bench shifts mosi on spiclk rises and captures 0x01, 0xF8000000, 0x12345678. done is high for exactly 1 cycle at E0+290. dout is still 0.
- Read addr=0x00001000 with the bench miso model driving 0xDEADBEEF after 8 turnaround periods → dout=0xDEADBEEF at E0+322. mosi=0 throughout turnaround and data.
- req held high for two writes → the second spiss fall is 2·CLKDIV+1 cycles after the first rise. busy is low for 1 cycle. Both frames are bit-exact.
- Pulse req at E0+10 during a write → ignored: one frame only, one done pulse.
- rst_n pulled low at E0+100 during a read → spiss=1, spiclk=0, busy=0 immediately and dout=0. A new read after reset completes correctly.
- CLKDIV=1, write → spiclk toggles every cycle, done at E0+145, stream correct.

Source files
------------

// File: rtl/jtpocket_bridge_host.sv
// Pocket bridge SPI initiator (APF host side): frames single-word read/write
// requests as mode-0 SPI transactions and returns read data with a done pulse.
module jtpocket_bridge_host #(
    parameter int CLKDIV = 2,
    parameter int TURN   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        busy,
    output logic        done,
    output logic        spiclk,
    output logic        spimosi,
    input  logic        spimiso,
    output logic        spiss
);

    localparam int NW = 72;
    localparam int NR = 72 + TURN;
    localparam int CW = $clog2(2 * CLKDIV + 1);
    localparam int BW = $clog2(NR);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKDIV);
    localparam logic [CW-1:0] CNT_GAP  = CW'(2 * CLKDIV);
    localparam logic [BW-1:0] LAST_W   = BW'(NW - 1);
    localparam logic [BW-1:0] LAST_R   = BW'(NR - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bit_cnt;
    logic [71:0]     tx_sr;
    logic [31:0]     rx_sr;
    logic            we_l;
    logic            half_end;
    logic            gap_end;
    logic            last_bit;

    always_comb begin
        half_end  = (cnt == CNT_HALF);
        gap_end   = (cnt == CNT_GAP);
        last_bit  = (bit_cnt == (we_l ? LAST_W : LAST_R));
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = SHIFT;
            SHIFT:   if (half_end && spiclk && last_bit) state_nxt = HOLD;
            HOLD:    if (half_end) state_nxt = GAP;
            GAP:     if (gap_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Read frames load zeros behind the address so mosi stays low through
    // turnaround and data without any extra masking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            we_l    <= 1'b0;
            dout    <= '0;
            done    <= 1'b0;
            spiclk  <= 1'b0;
            spiss   <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_l    <= we;
                        tx_sr   <= {(we ? 8'h01 : 8'h02), addr, (we ? din : 32'h0)};
                        cnt     <= CW'(1);
                        bit_cnt <= '0;
                        spiclk  <= 1'b0;
                        spiss   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        cnt    <= CW'(1);
                        spiclk <= ~spiclk;
                        // End of a high phase: sample miso, present next mosi bit
                        if (spiclk) begin
                            rx_sr <= {rx_sr[30:0], spimiso};
                            tx_sr <= {tx_sr[70:0], 1'b0};
                            if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        cnt   <= CW'(1);
                        spiss <= 1'b1;
                        done  <= 1'b1;
                        if (!we_l) dout <= rx_sr;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign spimosi = tx_sr[71];

endmodule

// File: tb/tb_jtpocket_bridge_host.sv
// Self-checking bench for jtpocket_bridge_host: a CLKDIV=2 and a CLKDIV=1 instance
// driven with directed and random transactions, checked against frame timing arithmetic.
module tb_jtpocket_bridge_host;

    localparam int TURN = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  miso;
    logic [31:0] addr_v [2];
    logic [31:0] din_v  [2];
    wire  [31:0] dout0, dout1;
    wire  [1:0]  busy, done, spiclk, mosi, ss;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] exp_dout [2];
    int last_rise_cyc [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jtpocket_bridge_host #(.CLKDIV(2), .TURN(TURN)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr_v[0]),
        .din(din_v[0]), .dout(dout0), .busy(busy[0]), .done(done[0]),
        .spiclk(spiclk[0]), .spimosi(mosi[0]), .spimiso(miso[0]), .spiss(ss[0])
    );

    jtpocket_bridge_host #(.CLKDIV(1), .TURN(TURN)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr_v[1]),
        .din(din_v[1]), .dout(dout1), .busy(busy[1]), .done(done[1]),
        .spiclk(spiclk[1]), .spimosi(mosi[1]), .spimiso(miso[1]), .spiss(ss[1])
    );

    function automatic logic [31:0] get_dout(input int sel);
        return (sel == 0) ? dout0 : dout1;
    endfunction

    task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Runs one frame starting at the next clock edge and checks it against
    // the frame layout and edge arithmetic; inj_at/rst_at perturb it mid-frame.
    task automatic applyStimulus(input int sel, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [31:0] mw,
                                 input bit hold_req, input bit b2b,
                                 input int inj_at, input int rst_at);
        int c, n, t_done, t_end, e0_cyc, k;
        int rises, bad_rise, dones, t_done_obs, t_ss_rise, t_busy_fall, bad_edge, zero_viol;
        logic [71:0] exp_stream, obs_stream;
        logic prev_clk, prev_mosi;
        c = (sel == 0) ? 2 : 1;
        n = w ? 72 : 72 + TURN;
        t_done = (2 * n + 1) * c;
        t_end  = (2 * n + 3) * c;
        exp_stream = w ? {8'h01, a, d} : {8'h02, a, 32'h0};
        obs_stream = '0;
        rises = 0; bad_rise = 0; dones = 0; t_done_obs = -1; t_ss_rise = -1;
        t_busy_fall = -1; bad_edge = 0; zero_viol = 0;

        we[sel] = w; addr_v[sel] = a; din_v[sel] = d; req[sel] = 1'b1;
        miso[sel] = 1'($urandom);
        @(posedge clk);
        #1;
        e0_cyc = cyc;
        checkOutput("accept_ss", {71'd0, ss[sel]}, 72'd0);
        checkOutput("accept_busy", {71'd0, busy[sel]}, 72'd1);
        if (b2b) checkOutput("ss_high_gap", 72'(e0_cyc - last_rise_cyc[sel]), 72'(2 * c + 1));
        if (!hold_req) req[sel] = 1'b0;
        we[sel] = $urandom; addr_v[sel] = $urandom; din_v[sel] = $urandom;
        prev_clk = spiclk[sel];
        prev_mosi = mosi[sel];

        for (int t = 1; t <= t_end; t++) begin
            @(posedge clk);
            #1;
            if (t == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                checkOutput("rst_ss", {71'd0, ss[sel]}, 72'd1);
                checkOutput("rst_spiclk", {71'd0, spiclk[sel]}, 72'd0);
                checkOutput("rst_busy", {71'd0, busy[sel]}, 72'd0);
                checkOutput("rst_dout", {40'd0, get_dout(sel)}, 72'd0);
                exp_dout[0] = '0;
                exp_dout[1] = '0;
                req[sel] = 1'b0;
                miso[sel] = 1'b0;
                return;
            end
            if (spiclk[sel] && !prev_clk) begin
                if (t != (2 * rises + 1) * c) bad_rise++;
                if (rises < 72) obs_stream = {obs_stream[70:0], mosi[sel]};
                if (!w && rises >= 40 && mosi[sel]) zero_viol++;
                k = rises;
                if (!w && k >= n - 32) miso[sel] = mw[31 - (k - (n - 32))];
                else miso[sel] = 1'($urandom);
                rises++;
            end
            if (mosi[sel] != prev_mosi && (t % (2 * c)) != 0) bad_edge++;
            if (done[sel]) begin dones++; t_done_obs = t; end
            if (ss[sel] && t_ss_rise < 0) t_ss_rise = t;
            if (!busy[sel] && t_busy_fall < 0) t_busy_fall = t;
            prev_clk = spiclk[sel];
            prev_mosi = mosi[sel];
            if (t + 1 == inj_at) req[sel] = 1'b1;
            else if (t == inj_at && !hold_req) req[sel] = 1'b0;
        end

        if (!w) exp_dout[sel] = mw;
        checkOutput("mosi_stream", obs_stream, exp_stream);
        checkOutput("rise_count", 72'(rises), 72'(n));
        checkOutput("rise_timing", 72'(bad_rise), 72'd0);
        checkOutput("mosi_edge", 72'(bad_edge), 72'd0);
        checkOutput("done_pulses", 72'(dones), 72'd1);
        checkOutput("done_time", 72'(t_done_obs), 72'(t_done));
        checkOutput("ss_rise_time", 72'(t_ss_rise), 72'(t_done));
        checkOutput("busy_fall_time", 72'(t_busy_fall), 72'(t_end));
        if (!w) checkOutput("read_mosi_zero", 72'(zero_viol), 72'd0);
        checkOutput("dout", {40'd0, get_dout(sel)}, {40'd0, exp_dout[sel]});
        last_rise_cyc[sel] = e0_cyc + t_ss_rise;
    endtask

    initial begin
        int ss_low;
        logic w;
        int sel;
        rst_n = 1'b0;
        req = '0; we = '0; miso = '0;
        for (int i = 0; i < 2; i++) begin
            addr_v[i] = '0; din_v[i] = '0; exp_dout[i] = '0; last_rise_cyc[i] = 0;
        end
        idle(3);
        for (int i = 0; i < 2; i++) begin
            checkOutput("reset_ss", {71'd0, ss[i]}, 72'd1);
            checkOutput("reset_spiclk", {71'd0, spiclk[i]}, 72'd0);
            checkOutput("reset_busy_done_mosi", {69'd0, busy[i], done[i], mosi[i]}, 72'd0);
            checkOutput("reset_dout", {40'd0, get_dout(i)}, 72'd0);
        end
        rst_n = 1'b1;
        idle(3);
        checkOutput("idle_no_req", {70'd0, ss}, 72'd3);

        applyStimulus(0, 1'b1, 32'hF800_0000, 32'h1234_5678, 32'h0, 0, 0, -1, -1);
        idle(2);
        applyStimulus(0, 1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0, 0, -1, -1);
        idle(2);

        applyStimulus(0, 1'b1, 32'hA5A5_0001, 32'h0BAD_F00D, 32'h0, 1, 0, -1, -1);
        applyStimulus(0, 1'b1, 32'h5A5A_0002, 32'hCAFE_1234, 32'h0, 0, 1, -1, -1);
        idle(2);

        applyStimulus(0, 1'b1, 32'h0000_00F0, 32'h8765_4321, 32'h0, 0, 0, 10, -1);
        ss_low = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (!ss[0]) ss_low++;
        end
        checkOutput("no_second_frame", 72'(ss_low), 72'd0);

        applyStimulus(0, 1'b0, 32'h0000_2000, 32'h0, 32'h1357_9BDF, 0, 0, -1, 100);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        applyStimulus(0, 1'b0, 32'h0000_3000, 32'h0, 32'h2468_ACE0, 0, 0, -1, -1);
        idle(2);

        applyStimulus(1, 1'b1, 32'hF800_0004, 32'h0F1E_2D3C, 32'h0, 0, 0, -1, -1);
        idle(2);

        for (int i = 0; i < 8; i++) begin
            sel = int'($urandom_range(1, 0));
            w = 1'($urandom);
            applyStimulus(sel, w, $urandom, $urandom, $urandom, 0, 0, -1, -1);
            idle(int'($urandom_range(3, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
